l2cache_plru_ctrl: RTL and testbench

- Sequencer for the L2 tree-PLRU replacement state; sits directly upstream of the 128-entry x 7-bit L2 PLRU SRAM and drives its address/data/write-enable.
- Per request: read the set's 7-bit PLRU word, pick a victim (alloc) or take the hit way (touch), write the updated word back, return the way.
- Clears all 128 entries after reset.

---
 rtl/l2cache_plru_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_l2cache_plru_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2cache_plru_ctrl.sv
// ---------------------------------------------------------------------------
// l2cache_plru_ctrl
//
// Sequencer for the L2 tree-PLRU replacement state. It owns the address,
// data and write-enable of the 128 x 7-bit PLRU SRAM and serialises each
// request as: read the set's PLRU word, choose the way (hit echo or victim),
// write the updated word back, then return the way and the old word.
// After reset every entry is swept to zero before the first request is
// accepted.
//
// Tree encoding: node n has children 2n+1 / 2n+2; a bit of 0 means the
// victim lies on the left/lower side. Leaves 3..6 pick way 2*(k-3)+bit.
//
// Optional feature macro: L2_PLRU_STATS_EN
//   When defined, stat_hit_cnt / stat_alloc_cnt count accepted touches and
//   allocs (saturating at 16'hFFFF, cleared by reset and during the sweep).
//
// Ports:
//   clk, rst         system clock (also clocks the SRAM), async active-high reset
//   req_valid/ready  request handshake; req_set, req_op (0 touch, 1 alloc),
//                    req_way (hit way, ignored for alloc)
//   resp_valid/ready response handshake; resp_way, resp_plru_old
//   sram_en/we/addr/din  SRAM controls (we=1 write), sram_dout read data valid
//                        the cycle after a read is issued
//   stat_hit_cnt, stat_alloc_cnt  (only with L2_PLRU_STATS_EN)
//
// All outputs are driven straight from flops. Each flop <sig>_q is loaded
// from <sig>_d, which is computed from the state being entered, so the
// registered outputs always describe the state currently held in state_q.
// ---------------------------------------------------------------------------
module l2cache_plru_ctrl #(
  parameter int SETS  = 128,
  parameter int IDX_W = 7,
  parameter int WAYS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [IDX_W-1:0]         req_set,
  input  logic                     req_op,
  input  logic [$clog2(WAYS)-1:0]  req_way,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(WAYS)-1:0]  resp_way,
  output logic [WAYS-2:0]          resp_plru_old,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [IDX_W-1:0]         sram_addr,
  output logic [WAYS-2:0]          sram_din,
  input  logic [WAYS-2:0]          sram_dout
`ifdef L2_PLRU_STATS_EN
  ,
  output logic [15:0]              stat_hit_cnt,
  output logic [15:0]              stat_alloc_cnt
`endif
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int TREE_W = WAYS - 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    CALC = 3'd3,
    WR   = 3'd4,
    RESP = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Tree helpers (8-way, 7-bit tree)
  // -------------------------------------------------------------------------

  // Walk the tree following the bits to the least-recently-used way.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] b);
    logic [WAY_W-1:0] w;
    logic [2:0]       mid_idx;
    logic [2:0]       leaf_idx;
    w        = 3'd0;
    w[2]     = b[0];
    mid_idx  = 3'd1 + {2'b00, w[2]};
    w[1]     = b[mid_idx];
    leaf_idx = 3'd3 + {1'b0, w[2:1]};
    w[0]     = b[leaf_idx];
    return w;
  endfunction

  // Point every node on the path to way w away from it; other bits untouched.
  function automatic logic [TREE_W-1:0] plru_update(input logic [TREE_W-1:0] b,
                                                    input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] nb;
    logic [2:0]        mid_idx;
    logic [2:0]        leaf_idx;
    nb           = b;
    mid_idx      = 3'd1 + {2'b00, w[2]};
    leaf_idx     = 3'd3 + {1'b0, w[2:1]};
    nb[0]        = ~w[2];
    nb[mid_idx]  = ~w[1];
    nb[leaf_idx] = ~w[0];
    return nb;
  endfunction

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state_q,         state_d;
  logic [IDX_W-1:0]   init_cnt_q,      init_cnt_d;
  logic [IDX_W-1:0]   set_q,           set_d;
  logic               op_q,            op_d;
  logic [WAY_W-1:0]   way_q,           way_d;
  logic               req_ready_q,     req_ready_d;
  logic               resp_valid_q,    resp_valid_d;
  logic [WAY_W-1:0]   resp_way_q,      resp_way_d;
  logic [TREE_W-1:0]  resp_plru_old_q, resp_plru_old_d;
  logic               sram_en_q,       sram_en_d;
  logic               sram_we_q,       sram_we_d;
  logic [IDX_W-1:0]   sram_addr_q,     sram_addr_d;
  logic [TREE_W-1:0]  sram_din_q,      sram_din_d;
`ifdef L2_PLRU_STATS_EN
  logic [15:0]        hit_cnt_q,       hit_cnt_d;
  logic [15:0]        alloc_cnt_q,     alloc_cnt_d;
`endif

  logic [WAY_W-1:0]   way_sel;

  // Way being touched this request: the hit way echoed, or the tree victim.
  always_comb begin
    if (op_q) begin
      way_sel = plru_victim(sram_dout);
    end else begin
      way_sel = way_q;
    end
  end

  // Next-state and next-output logic; every _d holds its _q unless overridden.
  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    set_d           = set_q;
    op_d            = op_q;
    way_d           = way_q;
    req_ready_d     = req_ready_q;
    resp_valid_d    = resp_valid_q;
    resp_way_d      = resp_way_q;
    resp_plru_old_d = resp_plru_old_q;
    sram_en_d       = sram_en_q;
    sram_we_d       = sram_we_q;
    sram_addr_d     = sram_addr_q;
    sram_din_d      = sram_din_q;
`ifdef L2_PLRU_STATS_EN
    hit_cnt_d       = hit_cnt_q;
    alloc_cnt_d     = alloc_cnt_q;
`endif

    case (state_q)
      INIT: begin
`ifdef L2_PLRU_STATS_EN
        hit_cnt_d   = 16'd0;
        alloc_cnt_d = 16'd0;
`endif
        sram_din_d  = '0;
        req_ready_d = 1'b0;
        // sram_en_q low here only in the first cycle out of reset: the
        // write of address 0 has not been presented yet.
        if (!sram_en_q) begin
          init_cnt_d  = '0;
          sram_en_d   = 1'b1;
          sram_we_d   = 1'b1;
          sram_addr_d = '0;
        end else if (init_cnt_q == LAST_SET) begin
          state_d     = IDLE;
          sram_en_d   = 1'b0;
          sram_we_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          init_cnt_d  = init_cnt_q + 1'b1;
          sram_en_d   = 1'b1;
          sram_we_d   = 1'b1;
          sram_addr_d = init_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        sram_en_d = 1'b0;
        sram_we_d = 1'b0;
        if (req_valid && req_ready_q) begin
          set_d       = req_set;
          op_d        = req_op;
          way_d       = req_way;
          req_ready_d = 1'b0;
          sram_en_d   = 1'b1;
          sram_we_d   = 1'b0;
          sram_addr_d = req_set;
          state_d     = RD;
`ifdef L2_PLRU_STATS_EN
          if (req_op) begin
            alloc_cnt_d = sat_inc16(alloc_cnt_q);
          end else begin
            hit_cnt_d   = sat_inc16(hit_cnt_q);
          end
`endif
        end else begin
          req_ready_d = 1'b1;
        end
      end

      RD: begin
        // Read is on the bus this cycle; data returns during CALC.
        sram_en_d = 1'b0;
        sram_we_d = 1'b0;
        state_d   = CALC;
      end

      CALC: begin
        resp_plru_old_d = sram_dout;
        resp_way_d      = way_sel;
        sram_din_d      = plru_update(sram_dout, way_sel);
        sram_en_d       = 1'b1;
        sram_we_d       = 1'b1;
        sram_addr_d     = set_q;
        state_d         = WR;
      end

      WR: begin
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

      RESP: begin
        sram_en_d = 1'b0;
        sram_we_d = 1'b0;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: restart the sweep from a clean slate.
        state_d         = INIT;
        init_cnt_d      = '0;
        req_ready_d     = 1'b0;
        resp_valid_d    = 1'b0;
        resp_way_d      = '0;
        resp_plru_old_d = '0;
        sram_en_d       = 1'b0;
        sram_we_d       = 1'b0;
        sram_addr_d     = '0;
        sram_din_d      = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= INIT;
      init_cnt_q      <= '0;
      set_q           <= '0;
      op_q            <= 1'b0;
      way_q           <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_way_q      <= '0;
      resp_plru_old_q <= '0;
      sram_en_q       <= 1'b0;
      sram_we_q       <= 1'b0;
      sram_addr_q     <= '0;
      sram_din_q      <= '0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      set_q           <= set_d;
      op_q            <= op_d;
      way_q           <= way_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_way_q      <= resp_way_d;
      resp_plru_old_q <= resp_plru_old_d;
      sram_en_q       <= sram_en_d;
      sram_we_q       <= sram_we_d;
      sram_addr_q     <= sram_addr_d;
      sram_din_q      <= sram_din_d;
    end
  end

`ifdef L2_PLRU_STATS_EN
  // Statistics counters with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q   <= 16'd0;
      alloc_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      alloc_cnt_q <= alloc_cnt_d;
    end
  end

  assign stat_hit_cnt   = hit_cnt_q;
  assign stat_alloc_cnt = alloc_cnt_q;
`endif

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_way      = resp_way_q;
  assign resp_plru_old = resp_plru_old_q;
  assign sram_en       = sram_en_q;
  assign sram_we       = sram_we_q;
  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;

endmodule

// File: tb/tb_l2cache_plru_ctrl.sv
// Testbench for l2cache_plru_ctrl: behavioural PLRU SRAM, a write scoreboard
// and a response scoreboard fed by the stimulus process and drained by
// independent monitors.
module tb_l2cache_plru_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_set;
  logic       req_op;
  logic [2:0] req_way;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_way;
  logic [6:0] resp_plru_old;
  logic       sram_en;
  logic       sram_we;
  logic [6:0] sram_addr;
  logic [6:0] sram_din;
  logic [6:0] sram_dout;

  int tests;
  int fails;
  int cyc;

  logic [13:0] wq[$];   // {addr, data} of expected SRAM writes
  logic [9:0]  rq[$];   // {way, old word} of expected responses

  logic [6:0] mem [0:127];

  l2cache_plru_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_set       (req_set),
    .req_op        (req_op),
    .req_way       (req_way),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_way      (resp_way),
    .resp_plru_old (resp_plru_old),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port SRAM model.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Write monitor: every SRAM write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && sram_en && sram_we) begin
      if (wq.size() == 0) begin
        chk("sram_wr_unexpected", {18'd0, sram_addr, sram_din}, 32'hFFFF_FFFF);
      end else begin
        chk("sram_wr", {18'd0, sram_addr, sram_din}, {18'd0, wq.pop_front()});
      end
    end
  end

  // Response monitor: pops on each response handshake.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (rq.size() == 0) begin
        chk("resp_unexpected", {22'd0, resp_way, resp_plru_old}, 32'hFFFF_FFFF);
      end else begin
        chk("resp", {22'd0, resp_way, resp_plru_old}, {22'd0, rq.pop_front()});
      end
    end
  end

  // Load the 128 sweep writes, release reset and time req_ready rising.
  task automatic init_sweep();
    int n;
    for (int i = 0; i < 128; i++) wq.push_back({i[6:0], 7'h00});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (req_ready) break;
    end
    chk("init_ready_cycle", n, 32'd129);
    chk("init_writes_left", wq.size(), 32'd0);
  endtask

  task automatic issue(input logic [6:0] set, input logic op, input logic [2:0] way,
                       input logic [2:0] exp_way, input logic [6:0] exp_old,
                       input logic [6:0] exp_new, input logic push_resp,
                       input logic chk_lat);
    int n;
    int hs;
    wq.push_back({set, exp_new});
    if (push_resp) rq.push_back({exp_way, exp_old});
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_set   = set;
    req_op    = op;
    req_way   = way;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
    hs = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (chk_lat) begin
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        if (resp_valid) break;
        n++;
      end
      chk("latency", cyc - hs, 32'd4);
    end
  endtask

  initial begin
    int n;
    cyc        = 0;
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_set    = 7'd0;
    req_op     = 1'b0;
    req_way    = 3'd0;
    resp_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 7'h55;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {4'd0, req_ready, resp_valid, resp_way, resp_plru_old,
                          sram_en, sram_we, sram_addr, sram_din}, 32'd0);

    init_sweep();

    // Three allocs on set 5 walk the tree: way 0, 4, 2.
    issue(7'd5, 1'b1, 3'd0, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);
    issue(7'd5, 1'b1, 3'd0, 3'd4, 7'h0B, 7'h2E, 1'b1, 1'b1);
    issue(7'd5, 1'b1, 3'd0, 3'd2, 7'h2E, 7'h3D, 1'b1, 1'b1);
    // Touch way 7 on set 9 leaves the word at zero; alloc then picks way 0.
    issue(7'd9, 1'b0, 3'd7, 3'd7, 7'h00, 7'h00, 1'b1, 1'b1);
    issue(7'd9, 1'b1, 3'd5, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);
    // Touch way 3 on set 5 (old 3D).
    issue(7'd5, 1'b0, 3'd3, 3'd3, 7'h3D, 7'h2D, 1'b1, 1'b1);
    // Boundary sets.
    issue(7'd127, 1'b0, 3'd0, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);
    issue(7'd0, 1'b1, 3'd0, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);

    // Stall in RESP for 10 cycles: alloc set 5 (old 2D) picks way 6.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    issue(7'd5, 1'b1, 3'd0, 3'd6, 7'h2D, 7'h68, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {17'd0, resp_valid, resp_way, resp_plru_old, req_ready, sram_en, sram_we},
          {17'd0, 1'b1, 3'd6, 7'h2D, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_resp_popped", rq.size(), 32'd0);

    // Reset during WR: alloc set 5 (old 68) would pick way 1 and write 63.
    issue(7'd5, 1'b1, 3'd0, 3'd1, 7'h68, 7'h63, 1'b0, 1'b0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (sram_en && sram_we) break;
      n++;
    end
    chk("wr_seen", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_in_wr", {28'd0, sram_we, sram_en, resp_valid, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    init_sweep();
    // Sweep cleared set 5 and set 9.
    issue(7'd5, 1'b1, 3'd0, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);
    issue(7'd9, 1'b1, 3'd0, 3'd0, 7'h00, 7'h0B, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
